// File: rtl/i2c_rx_shifter_pkg.sv
// Shared types for the I2C receive bit engine.
// State encoding and default sizing used by i2c_rx_shifter.
package i2c_rx_shifter_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_ACK  = 2'd2
  } rx_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DATA_W_DEF      = 8;

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for one I2C pad.
// Adds a delay flop and produces rise/fall strobes in the pclk domain.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2  // must be >= 2
) (
  input  logic pclk,
  input  logic prst_n,
  input  logic din,
  output logic sig_s,
  output logic sig_d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;

  // Flops reset high so an idle (pulled-up) bus produces no edges at release.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      sync_q <= '1;
      sig_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      sig_d  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];
  assign rise  = sig_s & ~sig_d;
  assign fall  = ~sig_s & sig_d;

endmodule

// File: rtl/i2c_rx_shifter.sv
// I2C receive bit engine: detects START/STOP, shifts bytes MSB-first,
// strobes each completed byte into the receive FIFO and drives ACK/NACK.
module i2c_rx_shifter
  import i2c_rx_shifter_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DATA_W      = DATA_W_DEF
) (
  input  logic              pclk,
  input  logic              prst_n,
  input  logic              rx_en,
  input  logic              ack_en,
  input  logic              scl_i,
  input  logic              sda_i,
  input  logic              rxff_full,
  output logic [DATA_W-1:0] rxff_din,
  output logic              i_rxff_wr,
  output logic              sda_oe,
  output logic              rx_busy,
  output logic              rx_start,
  output logic              rx_stop,
  output logic              rx_nack
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic scl_s, scl_d, scl_rise, scl_fall;
  logic sda_s, sda_d, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .pclk   (pclk),
    .prst_n (prst_n),
    .din    (scl_i),
    .sig_s  (scl_s),
    .sig_d  (scl_d),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .pclk   (pclk),
    .prst_n (prst_n),
    .din    (sda_i),
    .sig_s  (sda_s),
    .sig_d  (sda_d),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, scl_d, sda_rise, sda_fall};

  assign start_det = scl_s & sda_d & ~sda_s;
  assign stop_det  = scl_s & ~sda_d & sda_s;

  rx_state_e         state_q, state_n;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_n;
  logic [DATA_W-1:0] shift_q, shift_n;
  logic [DATA_W-1:0] din_n;
  logic              byte_full_q, byte_full_n;
  logic              oe_n, wr_n, start_n, stop_n, nack_n;
  logic              ack_ok;

  assign ack_ok = ack_en & ~rxff_full;

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      state_q     <= RX_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      byte_full_q <= 1'b0;
      rxff_din    <= '0;
      sda_oe      <= 1'b0;
      i_rxff_wr   <= 1'b0;
      rx_start    <= 1'b0;
      rx_stop     <= 1'b0;
      rx_nack     <= 1'b0;
    end else begin
      state_q     <= state_n;
      bitcnt_q    <= bitcnt_n;
      shift_q     <= shift_n;
      byte_full_q <= byte_full_n;
      rxff_din    <= din_n;
      sda_oe      <= oe_n;
      i_rxff_wr   <= wr_n;
      rx_start    <= start_n;
      rx_stop     <= stop_n;
      rx_nack     <= nack_n;
    end
  end

  // Bus conditions are checked before clock edges so they win in a shared cycle.
  always_comb begin
    state_n     = state_q;
    bitcnt_n    = bitcnt_q;
    shift_n     = shift_q;
    byte_full_n = byte_full_q;
    din_n       = rxff_din;
    oe_n        = sda_oe;
    wr_n        = 1'b0;
    start_n     = 1'b0;
    stop_n      = 1'b0;
    nack_n      = 1'b0;

    if (!rx_en) begin
      state_n     = RX_IDLE;
      bitcnt_n    = '0;
      byte_full_n = 1'b0;
      oe_n        = 1'b0;
    end else if (stop_det) begin
      state_n     = RX_IDLE;
      bitcnt_n    = '0;
      byte_full_n = 1'b0;
      oe_n        = 1'b0;
      stop_n      = 1'b1;
    end else if (start_det) begin
      state_n     = RX_DATA;
      bitcnt_n    = '0;
      shift_n     = '0;
      byte_full_n = 1'b0;
      oe_n        = 1'b0;
      start_n     = 1'b1;
    end else begin
      case (state_q)
        RX_DATA: begin
          if (scl_rise) begin
            shift_n = {shift_q[DATA_W-2:0], sda_s};
            if (bitcnt_q == CNT_LAST) begin
              bitcnt_n    = '0;
              byte_full_n = 1'b1;
            end else begin
              bitcnt_n = bitcnt_q + 1'b1;
            end
          end else if (scl_fall && byte_full_q) begin
            // A full FIFO still gets the strobe so it can flag overflow.
            din_n       = shift_q;
            wr_n        = 1'b1;
            byte_full_n = 1'b0;
            oe_n        = ack_ok;
            nack_n      = ~ack_ok;
            state_n     = RX_ACK;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            oe_n     = 1'b0;
            bitcnt_n = '0;
            state_n  = RX_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign rx_busy = (state_q != RX_IDLE);

endmodule
